sb_rx_gen2: RTL
===============

Name: sb_rx_gen2

Overview:
- Second-generation sideband receiver.
- Deserialises 64-bit sideband words from the forwarded serial clock/data pins and crosses them into the clk_100MHz domain with a toggle handshake.
- Buffers words in a parametrised FIFO with full/overflow tracking.
- Pairs each decoded header with its 0/32/64-bit payload, then delivers one complete message per ready/valid transfer to the LTSM.

Parameters:
- FIFO_DEPTH, 8, word FIFO entries; power of 2, >=2.
- SYNC_STAGES, 2, flops in the toggle synchroniser; >=2.
- AFULL_TH, FIFO_DEPTH-2, level at or above which afull_o asserts.

Ports:
- clk_100MHz  in  1  core clock.
- reset  in  1  asynchronous, active-high; clears both clock domains.
- enable_i  in  1  receive enable; quasi-static.
- clkPin_i  in  1  forwarded serial clock; data sampled on negedge.
- dataPin_i  in  1  serial data, LSB first.
- msg_ready_i  in  1  consumer accepts the current message.
- msg_valid_o  out  1  SB_msg_o/data_o valid.
- SB_msg_o  out  SB_msg_t  decoded message.
- data_o  out  64  payload; zero-extended when 32-bit.
- data_valid_o  out  1  payload present with this message.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- afull_o  out  1  fifo_level_o >= AFULL_TH.
- overflow_o  out  1  sticky; a word was dropped.
- clear_err_i  in  1  clears sticky error flags.

Behaviour:
- Reset values: all outputs 0; SB_msg_o = '0; FSM in S_IDLE; FIFO empty.
- Serial domain, each negedge clkPin_i while enable_i=1:
  - shift {dataPin_i, sr[63:1]}; bit counter increments.
  - On the 64th bit: load hold register, toggle tgl, clear counter.
  - While enable_i=0: counter held at 0 and no shifting.
- CDC:
  - tgl passes through SYNC_STAGES flops on clk_100MHz; an edge detector produces a one-cycle capture pulse.
  - The hold register is stable for >=63 serial clocks (>=7 core cycles), which exceeds the SYNC_STAGES+1 capture window.
  - Word pushed into the FIFO on the cycle after the edge, i.e. latency SYNC_STAGES+2 core cycles from the 64th negedge.
- FIFO:
  - Circular buffer; read/write pointers carry an extra wrap bit.
  - Full = pointers equal except the MSB; empty = pointers fully equal.
  - Push while full: word dropped and overflow_o <= 1.
  - Simultaneous push and pop while full: pop first, then push is accepted.
- Output FSM:
  - S_IDLE: if FIFO not empty, pop the header and decode it via the package decode function.
    - No payload: load SB_msg_o, data_valid_o=0, go to S_OUT.
    - Payload needed: latch message and payload size, go to S_DATA.
  - S_DATA: if FIFO not empty, pop the payload; data_o = full word (64b) or {32'd0, word[31:0]}; data_valid_o=1; go to S_OUT.
  - S_OUT: msg_valid_o=1; outputs held stable. On msg_ready_i=1 the transfer completes: msg_valid_o=0 next cycle, go to S_IDLE.
  - Header-only latency: msg_valid_o rises 2 cycles after the FIFO becomes non-empty. Back-to-back transfers need >=1 idle cycle between them.
- Error handling:
  - overflow_o is cleared by clear_err_i unless a new overflow occurs in the same cycle, in which case set wins.
  - Pairing after an overflow is not repaired; the LTSM resets the link.
- enable_i=0 stops reception only; the output FSM keeps draining the FIFO.
- Reset mid-word: partial bits are discarded and the toggle is cleared in both domains.

Optional Feature:
- SB_RX_PARITY_CHK_EN defined:
  - Header must have even XOR over bits [63:0], with header bit SB_CP_BIT (package constant) as control parity.
  - XOR of payload bits must equal header bit SB_DP_BIT.
  - On mismatch: parity_err_o (extra 1-bit output) is set sticky, the message is still delivered, and clear_err_i clears the flag.
- Undefined: no parity logic and no parity_err_o port.

Decomposition:
- Shared package SB_codex_pkg: SB_msg_t, decode function, SB_CP_BIT / SB_DP_BIT constants, payload-size enum.
- FSM state enum is local to the module.
- Sub-module sb_rx_deser: serial-domain shifter, hold register and toggle.
- FIFO, synchroniser and FSM stay in the top module.

Test Plan:
- Single header-only word, msg_ready_i=1 -> msg_valid_o pulses once, data_valid_o=0, fifo_level_o returns to 0.
- Header expecting 64b followed by 64'hDEAD_BEEF_0123_4567 -> one transfer, data_o=64'hDEAD_BEEF_0123_4567, data_valid_o=1.
- Header expecting 32b followed by 64'hFFFF_FFFF_A5A5_5A5A -> data_o=64'h0000_0000_A5A5_5A5A.
- msg_ready_i=0, send FIFO_DEPTH+2 words -> afull_o at level 6, level saturates at 8, overflow_o=1. Then assert clear_err_i and release ready -> 8 words drain in order and overflow_o=0.
- Assert reset after 30 serial bits, then send a full word -> only the new word is received and no spurious message appears.
- With SB_RX_PARITY_CHK_EN defined, flip SB_CP_BIT -> message delivered and parity_err_o=1 until clear_err_i.

Source files
------------

// File: rtl/sb_rx_gen2_pkg.sv
// Shared sideband codec definitions: message type, payload-size enum,
// parity bit positions and the header decode function.
package SB_codex_pkg;

    // Payload size announced by a header.
    typedef enum logic [1:0] {
        PL_NONE = 2'd0,
        PL_32   = 2'd1,
        PL_64   = 2'd2
    } sb_plen_e;

    // Decoded sideband message.
    typedef struct packed {
        sb_plen_e    plen;
        logic [4:0]  opcode;
        logic [7:0]  msg_code;
        logic [15:0] msg_info;
    } SB_msg_t;

    // Header bit carrying control parity (header XOR must be even).
    localparam int unsigned SB_CP_BIT = 62;
    // Header bit carrying the expected XOR of the payload.
    localparam int unsigned SB_DP_BIT = 63;

    // Header layout: opcode [4:0], msg_code [21:14], msg_info [39:24].
    // Opcode class opcode[4:3]: 01 -> 32b payload, 10 -> 64b payload, else none.
    function automatic SB_msg_t sb_decode(input logic [63:0] hdr);
        SB_msg_t m;
        m.opcode   = hdr[4:0];
        m.msg_code = hdr[21:14];
        m.msg_info = hdr[39:24];
        case (hdr[4:3])
            2'b01:   m.plen = PL_32;
            2'b10:   m.plen = PL_64;
            default: m.plen = PL_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sb_rx_gen2_if.sv
// Message delivery interface between the sideband receiver and the LTSM.
interface sb_rx_gen2_if;
    import SB_codex_pkg::*;

    logic        msg_ready_i;
    logic        msg_valid_o;
    SB_msg_t     SB_msg_o;
    logic [63:0] data_o;
    logic        data_valid_o;

    modport master (
        input  msg_ready_i,
        output msg_valid_o,
        output SB_msg_o,
        output data_o,
        output data_valid_o
    );

    modport slave (
        output msg_ready_i,
        input  msg_valid_o,
        input  SB_msg_o,
        input  data_o,
        input  data_valid_o
    );

endinterface

// File: rtl/sb_rx_gen2_deser.sv
// Serial-domain deserialiser: shifts LSB-first bits on the falling edge of the
// forwarded clock, parks each complete 64-bit word in a hold register and
// toggles a flag for the core-domain synchroniser.
module sb_rx_deser (
    input  logic        clk_pin,
    input  logic        reset,
    input  logic        enable,
    input  logic        data_pin,
    output logic [63:0] hold,
    output logic        tgl
);

    logic [62:0] sr_q;
    logic [5:0]  cnt_q;
    logic [63:0] hold_q;
    logic        tgl_q;

    // Shift, count and hand off a word on every 64th enabled falling edge.
    always_ff @(negedge clk_pin or posedge reset) begin
        if (reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            hold_q <= '0;
            tgl_q  <= 1'b0;
        end else if (!enable) begin
            cnt_q <= '0;
        end else begin
            sr_q <= {data_pin, sr_q[62:1]};
            if (cnt_q == 6'd63) begin
                hold_q <= {data_pin, sr_q};
                tgl_q  <= ~tgl_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 6'd1;
            end
        end
    end

    assign hold = hold_q;
    assign tgl  = tgl_q;

endmodule

// File: rtl/sb_rx_gen2.sv
// Second-generation sideband receiver top: serial deserialiser, toggle CDC,
// word FIFO and header/payload pairing FSM feeding the LTSM.
// Optional build macro: SB_RX_PARITY_CHK_EN adds header/payload parity
// checking and the sticky parity_err_o output.
module sb_rx_gen2
    import SB_codex_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AFULL_TH    = FIFO_DEPTH - 2
) (
    input  logic                          clk_100MHz,
    input  logic                          reset,
    input  logic                          enable_i,
    input  logic                          clkPin_i,
    input  logic                          dataPin_i,
    input  logic                          clear_err_i,
    sb_rx_gen2_if.master                  bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          afull_o,
    output logic                          overflow_o
`ifdef SB_RX_PARITY_CHK_EN
    ,
    output logic                          parity_err_o
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PtrOne   = (AW + 1)'(1);
    localparam logic [AW:0] AfullLvl = (AW + 1)'(AFULL_TH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    // ---------------------------------------------------------------------
    // Serial domain
    // ---------------------------------------------------------------------
    logic [63:0] hold_word;
    logic        tgl_ser;

    sb_rx_deser u_deser (
        .clk_pin  (clkPin_i),
        .reset    (reset),
        .enable   (enable_i),
        .data_pin (dataPin_i),
        .hold     (hold_word),
        .tgl      (tgl_ser)
    );

    // ---------------------------------------------------------------------
    // Toggle synchroniser and capture
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tgl_seen_q;
    logic                   tgl_edge;
    logic                   push_q;
    logic [63:0]            cap_word_q;

    assign tgl_edge = sync_q[SYNC_STAGES-1] ^ tgl_seen_q;

    // Synchronise the toggle; the hold register is long stable by the edge.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            tgl_seen_q <= 1'b0;
            push_q     <= 1'b0;
            cap_word_q <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tgl_ser};
            tgl_seen_q <= sync_q[SYNC_STAGES-1];
            push_q     <= tgl_edge;
            if (tgl_edge) begin
                cap_word_q <= hold_word;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Word FIFO
    // ---------------------------------------------------------------------
    logic [63:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push_ok;
    logic [63:0] rd_word;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push_q && (!full || pop);
    assign rd_word = mem_q[rptr_q[AW-1:0]];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_100MHz) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= cap_word_q;
        end
    end

    // Pointer and sticky overflow tracking; a new overflow beats clear.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
            end
            if (push_q && !push_ok) begin
                overflow_o <= 1'b1;
            end else if (clear_err_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

    assign fifo_level_o = wptr_q - rptr_q;
    assign afull_o      = (fifo_level_o >= AfullLvl);

    // ---------------------------------------------------------------------
    // Output FSM
    // ---------------------------------------------------------------------
    state_e      state_q, state_d;
    SB_msg_t     msg_q, msg_d;
    logic [63:0] data_q, data_d;
    logic        dvalid_q, dvalid_d;
    sb_plen_e    plen_q, plen_d;
    SB_msg_t     dec;

    assign dec = sb_decode(rd_word);

`ifdef SB_RX_PARITY_CHK_EN
    logic dp_q, dp_d;
    logic perr_set;
`endif

    // Next-state: pop header, optionally pop payload, then hold until accepted.
    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        data_d   = data_q;
        dvalid_d = dvalid_q;
        plen_d   = plen_q;
        pop      = 1'b0;
`ifdef SB_RX_PARITY_CHK_EN
        dp_d     = dp_q;
        perr_set = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    msg_d = dec;
`ifdef SB_RX_PARITY_CHK_EN
                    dp_d     = rd_word[SB_DP_BIT];
                    perr_set = ^rd_word;
`endif
                    if (dec.plen == PL_NONE) begin
                        data_d   = '0;
                        dvalid_d = 1'b0;
                        state_d  = S_OUT;
                    end else begin
                        plen_d  = dec.plen;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (!empty) begin
                    pop      = 1'b1;
                    data_d   = (plen_q == PL_64) ? rd_word : {32'd0, rd_word[31:0]};
                    dvalid_d = 1'b1;
                    state_d  = S_OUT;
`ifdef SB_RX_PARITY_CHK_EN
                    perr_set = (plen_q == PL_64) ? ((^rd_word) != dp_q)
                                                 : ((^rd_word[31:0]) != dp_q);
`endif
                end
            end
            S_OUT: begin
                if (bus.msg_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            msg_q    <= '0;
            data_q   <= '0;
            dvalid_q <= 1'b0;
            plen_q   <= PL_NONE;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            data_q   <= data_d;
            dvalid_q <= dvalid_d;
            plen_q   <= plen_d;
        end
    end

`ifdef SB_RX_PARITY_CHK_EN
    // Sticky parity error; a new error beats clear.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            dp_q         <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            dp_q <= dp_d;
            if (perr_set) begin
                parity_err_o <= 1'b1;
            end else if (clear_err_i) begin
                parity_err_o <= 1'b0;
            end
        end
    end
`endif

    assign bus.msg_valid_o  = (state_q == S_OUT);
    assign bus.SB_msg_o     = msg_q;
    assign bus.data_o       = data_q;
    assign bus.data_valid_o = dvalid_q;

endmodule
